// File: rtl/rle_capture_encoder.sv
// Run-length encoder between probe bus and capture memory: collapses repeated
// samples into {count, value} records buffered in a FWFT FIFO. Optional trigger-split via RLE_TRIGGER_EN.
module rle_capture_encoder #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          sys_run,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [CNT_WIDTH+DATA_WIDTH-1:0] rec_data,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic                          run_active,
    output logic                          overflow
`ifdef RLE_TRIGGER_EN
    ,
    input  logic [DATA_WIDTH-1:0]         trig_value,
    input  logic [DATA_WIDTH-1:0]         trig_mask,
    output logic                          trig_hit
`endif
);

    localparam int REC_W = CNT_WIDTH + DATA_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] cur_value, value_nxt;
    logic [CNT_WIDTH-1:0]  cur_count, count_nxt;
    logic                  push;
    logic [REC_W-1:0]      push_rec;
    logic                  trig_start;

`ifdef RLE_TRIGGER_EN
    logic trig_match, prev_match;

    // Only the rising edge of a match splits a run, so a held match does not chop every sample.
    assign trig_match = ((data_in ^ trig_value) & trig_mask) == '0;
    assign trig_start = (state == RUN) && sys_run && trig_match && !prev_match;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            prev_match <= 1'b0;
            trig_hit   <= 1'b0;
        end else begin
            prev_match <= trig_match;
            trig_hit   <= trig_start;
        end
    end
`else
    assign trig_start = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        value_nxt = cur_value;
        count_nxt = cur_count;
        push      = 1'b0;
        push_rec  = {cur_count, cur_value};
        case (state)
            IDLE: begin
                if (sys_run) begin
                    state_nxt = RUN;
                    value_nxt = data_in;
                    count_nxt = '0;
                end
            end
            RUN: begin
                if (!sys_run) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end else if (data_in != cur_value || trig_start) begin
                    push      = 1'b1;
                    value_nxt = data_in;
                    count_nxt = '0;
                end else if (cur_count == CMAX) begin
                    // Saturated: emit and restart the same value at count 0.
                    push      = 1'b1;
                    count_nxt = '0;
                end else begin
                    count_nxt = cur_count + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            cur_value <= '0;
            cur_count <= '0;
        end else begin
            state     <= state_nxt;
            cur_value <= value_nxt;
            cur_count <= count_nxt;
        end
    end

    assign run_active = (state == RUN);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic             empty, full, pop, wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = rec_valid && rec_ready;
    // A push into a full FIFO lands in the slot being popped the same edge.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_rec;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && !wr_en) overflow <= 1'b1;
        end
    end

    assign rec_valid = !empty;
    assign rec_data  = rec_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_rle_capture_encoder.sv
// Randomized and directed bench for rle_capture_encoder against a queue-based
// run-length reference model.
module tb_rle_capture_encoder;

    localparam int DW    = 16;
    localparam int CW    = 8;
    localparam int DEPTH = 4;
    localparam int CMAX  = 255;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          sys_run;
    logic [DW-1:0] data_in;
    logic [CW+DW-1:0] rec_data;
    logic          rec_valid;
    logic          rec_ready;
    logic          run_active;
    logic          overflow;

    always #5 clk = ~clk;

    rle_capture_encoder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_l(rst_l), .sys_run(sys_run), .data_in(data_in),
        .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .run_active(run_active), .overflow(overflow)
    );

    // Reference model: an open run is a value plus a number of samples seen.
    bit             m_run;
    logic [DW-1:0]  m_val;
    int             m_rep;
    logic [CW+DW-1:0] mq[$];
    bit             m_ovf;
    logic [CW+DW-1:0] got[$];
    int             n_vec = 0;
    int             n_err = 0;

    task automatic model_reset();
        m_run = 0; m_val = '0; m_rep = 0; m_ovf = 0;
        mq.delete(); got.delete();
    endtask

    function automatic logic [CW+DW+2:0] exp_out();
        logic [CW+DW-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        return {(mq.size() > 0), head, m_run, m_ovf};
    endfunction

    task automatic tick();
        bit pop, do_push;
        logic [CW+DW-1:0] rec;
        pop = (mq.size() > 0) && rec_ready;
        if (rec_valid && rec_ready) got.push_back(rec_data);
        do_push = 0;
        rec = '0;
        if (!m_run) begin
            if (sys_run) begin m_run = 1; m_val = data_in; m_rep = 1; end
        end else if (!sys_run) begin
            rec = {CW'(m_rep - 1), m_val}; do_push = 1; m_run = 0;
        end else if (data_in != m_val || m_rep == CMAX + 1) begin
            rec = {CW'(m_rep - 1), m_val}; do_push = 1; m_val = data_in; m_rep = 1;
        end else begin
            m_rep++;
        end
        if (pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(rec);
            else m_ovf = 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        sys_run = 0; rec_ready = 0; data_in = '0; rst_l = 0;
        repeat (2) @(posedge clk);
        #1 rst_l = 1;
        model_reset();
    endtask

    task automatic test_reset();
        sys_run = 1; rec_ready = 1; data_in = 16'h1234; rst_l = 0;
        #3;
        n_vec++;
        if ({rec_valid, rec_data, run_active, overflow} !== 27'h0) begin
            n_err++; $display("FAIL reset_state: got %h want 0", {rec_valid, rec_data, run_active, overflow});
        end
        apply_reset();
        tick();
        n_vec++;
        if ({rec_valid, rec_data, run_active, overflow} !== exp_out()) begin
            n_err++; $display("FAIL reset_idle: got %h want %h", {rec_valid, rec_data, run_active, overflow}, exp_out());
        end
    endtask

    task automatic test_constant();
        apply_reset();
        rec_ready = 1; sys_run = 1; data_in = 16'h00A5;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) sys_run = 0;
            tick();
            n_vec++;
            if ({rec_valid, rec_data, run_active, overflow} !== exp_out()) begin
                n_err++; $display("FAIL constant cyc %0d: got %h want %h", i, {rec_valid, rec_data, run_active, overflow}, exp_out());
            end
        end
        n_vec++;
        if (got.size() != 1 || got[0] !== {8'd4, 16'h00A5}) begin
            n_err++; $display("FAIL constant_record: got %0d records first %h want 1 record 0400a5", got.size(), (got.size() > 0) ? got[0] : 24'h0);
        end
    endtask

    task automatic test_sequence();
        logic [DW-1:0] seq [6] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
        logic [CW+DW-1:0] want [3] = '{{8'd1, 16'd1}, {8'd0, 16'd2}, {8'd2, 16'd3}};
        apply_reset();
        rec_ready = 1;
        for (int i = 0; i < 10; i++) begin
            sys_run = (i < 6);
            data_in = (i < 6) ? seq[i] : 16'hFFFF;
            tick();
            n_vec++;
            if ({rec_valid, rec_data, run_active, overflow} !== exp_out()) begin
                n_err++; $display("FAIL sequence cyc %0d: got %h want %h", i, {rec_valid, rec_data, run_active, overflow}, exp_out());
            end
        end
        n_vec++;
        if (got.size() != 3) begin
            n_err++; $display("FAIL sequence_count: got %0d want 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (got[k] !== want[k]) begin
                    n_err++; $display("FAIL sequence_rec%0d: got %h want %h", k, got[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_long_run();
        int sum;
        apply_reset();
        rec_ready = 1; data_in = 16'hBEEF;
        for (int i = 0; i < 304; i++) begin
            sys_run = (i < 300);
            tick();
            n_vec++;
            if ({rec_valid, rec_data, run_active, overflow} !== exp_out()) begin
                n_err++; $display("FAIL long_run cyc %0d: got %h want %h", i, {rec_valid, rec_data, run_active, overflow}, exp_out());
            end
        end
        sum = 0;
        foreach (got[k]) sum += int'(got[k][CW+DW-1:DW]) + 1;
        n_vec++;
        if (got.size() != 2 || got[0] !== {8'd255, 16'hBEEF} || got[1] !== {8'd43, 16'hBEEF} || sum != 300) begin
            n_err++; $display("FAIL long_run_records: got %0d records sum %0d want 2 records (ffbeef, 2bbeef) sum 300", got.size(), sum);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        rec_ready = 0; sys_run = 1;
        for (int i = 0; i < 6; i++) begin
            data_in = (i % 2 == 0) ? 16'd1 : 16'd0;
            tick();
            n_vec++;
            if ({rec_valid, rec_data, run_active, overflow} !== exp_out()) begin
                n_err++; $display("FAIL overflow cyc %0d: got %h want %h", i, {rec_valid, rec_data, run_active, overflow}, exp_out());
            end
            if (i >= 1) begin
                n_vec++;
                if (rec_data !== {8'd0, 16'd1}) begin
                    n_err++; $display("FAIL overflow_stable cyc %0d: got %h want 000001", i, rec_data);
                end
            end
        end
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++; $display("FAIL overflow_flag: got %b want 1", overflow);
        end
        rec_ready = 1; sys_run = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if ({rec_valid, rec_data, run_active, overflow} !== exp_out()) begin
                n_err++; $display("FAIL overflow_drain cyc %0d: got %h want %h", i, {rec_valid, rec_data, run_active, overflow}, exp_out());
            end
        end
        n_vec++;
        if (got.size() < 4 || got[0] !== 24'h000001 || got[1] !== 24'h000000 || got[2] !== 24'h000001 || got[3] !== 24'h000000) begin
            n_err++; $display("FAIL overflow_order: got %0d records want 01,00,01,00 first", got.size());
        end
    endtask

    task automatic test_full_pushpop();
        apply_reset();
        rec_ready = 0; sys_run = 1;
        for (int i = 0; i < 14; i++) begin
            sys_run   = (i < 11);
            rec_ready = (i >= 5);
            data_in   = (i % 2 == 0) ? 16'd1 : 16'd0;
            tick();
            n_vec++;
            if ({rec_valid, rec_data, run_active, overflow} !== exp_out()) begin
                n_err++; $display("FAIL full_pushpop cyc %0d: got %h want %h", i, {rec_valid, rec_data, run_active, overflow}, exp_out());
            end
        end
        repeat (4) tick();
        n_vec++;
        if (overflow !== 1'b0 || got.size() != 11) begin
            n_err++; $display("FAIL full_pushpop_nodrop: got ovf %b records %0d want ovf 0 records 11", overflow, got.size());
        end else begin
            for (int k = 0; k < 11; k++) begin
                n_vec++;
                if (got[k] !== {8'd0, (k % 2 == 0) ? 16'd1 : 16'd0}) begin
                    n_err++; $display("FAIL full_pushpop_rec%0d: got %h", k, got[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [DW-1:0] seq [4] = '{16'd3, 16'd3, 16'd4, 16'd5};
        apply_reset();
        rec_ready = 0; sys_run = 1;
        for (int i = 0; i < 4; i++) begin
            data_in = seq[i];
            tick();
        end
        n_vec++;
        if ({rec_valid, rec_data, run_active, overflow} !== exp_out() || mq.size() != 2) begin
            n_err++; $display("FAIL midrun_prefill: got %h want %h", {rec_valid, rec_data, run_active, overflow}, exp_out());
        end
        #2 rst_l = 0;
        #1;
        n_vec++;
        if ({rec_valid, rec_data, run_active, overflow} !== 27'h0) begin
            n_err++; $display("FAIL midrun_async: got %h want 0", {rec_valid, rec_data, run_active, overflow});
        end
        model_reset();
        @(posedge clk); #3 rst_l = 1;
        sys_run = 0; rec_ready = 1;
        for (int i = 0; i < 7; i++) begin
            sys_run = (i >= 3 && i < 5);
            data_in = 16'd7;
            tick();
            n_vec++;
            if ({rec_valid, rec_data, run_active, overflow} !== exp_out()) begin
                n_err++; $display("FAIL midrun_after cyc %0d: got %h want %h", i, {rec_valid, rec_data, run_active, overflow}, exp_out());
            end
        end
        n_vec++;
        if (got.size() != 1 || got[0] !== {8'd1, 16'd7}) begin
            n_err++; $display("FAIL midrun_records: got %0d records want 1 (010007)", got.size());
        end
    endtask

    task automatic test_toggle();
        bit runs [7] = '{1, 0, 1, 1, 0, 0, 0};
        apply_reset();
        rec_ready = 1; data_in = 16'd9;
        for (int i = 0; i < 7; i++) begin
            sys_run = runs[i];
            tick();
            n_vec++;
            if ({rec_valid, rec_data, run_active, overflow} !== exp_out()) begin
                n_err++; $display("FAIL toggle cyc %0d: got %h want %h", i, {rec_valid, rec_data, run_active, overflow}, exp_out());
            end
        end
        n_vec++;
        if (got.size() != 2 || got[0] !== {8'd0, 16'd9} || got[1] !== {8'd1, 16'd9}) begin
            n_err++; $display("FAIL toggle_records: got %0d records want 000009,010009", got.size());
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            sys_run   = ($urandom % 16) != 0;
            rec_ready = ($urandom % 3) != 0;
            // The middle stretch holds the value to exercise count saturation.
            if (i < 1000 || i >= 1700) begin
                if ($urandom % 3 == 0) data_in = 16'($urandom % 4);
            end else begin
                sys_run = 1; data_in = 16'h5A5A;
            end
            tick();
            n_vec++;
            if ({rec_valid, rec_data, run_active, overflow} !== exp_out()) begin
                n_err++; $display("FAIL random cyc %0d: got %h want %h", i, {rec_valid, rec_data, run_active, overflow}, exp_out());
            end
        end
    endtask

    initial begin
        rst_l = 0; sys_run = 0; rec_ready = 0; data_in = '0;
        model_reset();
        test_reset();
        test_constant();
        test_sequence();
        test_long_run();
        test_overflow();
        test_full_pushpop();
        test_reset_midrun();
        test_toggle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rle_capture_encoder.md
Name: rle_capture_encoder

Overview:
- Run-length compression stage between the probed design signals and the logic analyzer's capture memory.
- Samples the DATA_WIDTH probe bus every clock while sys_run is high and collapses runs of identical samples into {repeat_count, value} records.
- Records are buffered in a small FIFO and handed to the capture-memory writer over a valid/ready handshake, which raises the effective capture depth for slowly changing counters.

Parameters:
DATA_WIDTH, 16, width of the probe bus.
CNT_WIDTH, 8, width of the repeat-count field; max count CMAX = 2^CNT_WIDTH-1.
FIFO_DEPTH, 4, record FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  system clock, all logic on the rising edge.
rst_l  input  1  asynchronous active-low reset.
sys_run  input  1  capture enable from the analyzer control.
data_in  input  DATA_WIDTH  probe bus, sampled every clk.
rec_data  output  CNT_WIDTH+DATA_WIDTH  record {count, value}, count in the MSBs.
rec_valid  output  1  FIFO not empty.
rec_ready  input  1  consumer accepts the record this cycle.
run_active  output  1  a run is currently open.
overflow  output  1  sticky flag: a record was dropped.

Behaviour:
- Reset (rst_l=0, async): rec_data=0, rec_valid=0, run_active=0, overflow=0; FIFO empty; cur_value=0; cur_count=0; FSM=IDLE.
- count semantics: count = repeats-1, so count=0 means a single sample.
- FSM states: IDLE, RUN.
- IDLE, sys_run=1: cur_value<=data_in, cur_count<=0, go to RUN; run_active=1 from the next cycle.
- RUN, sys_run=1, data_in==cur_value, cur_count<CMAX: cur_count++.
- RUN, sys_run=1, data_in==cur_value, cur_count==CMAX: push {CMAX, cur_value}; start a new run with the same value and count 0.
- RUN, sys_run=1, data_in!=cur_value: push {cur_count, cur_value}; cur_value<=data_in; cur_count<=0.
- RUN, sys_run=0: push {cur_count, cur_value}; go to IDLE; the data_in of that cycle is not sampled.
- Latency: a record pushed at edge N appears on rec_data/rec_valid after edge N when the FIFO was empty (registered FIFO, first-word fall-through).
- Pop occurs on a rising edge with rec_valid && rec_ready. rec_data must stay stable while rec_valid=1 and rec_ready=0.
- Push into a full FIFO:
  - with a simultaneous pop, both occur and nothing is lost;
  - without a pop, the record is dropped and overflow<=1.
- overflow is cleared only by rst_l. Dropping a record does not disturb the run state.
- Push and pop on an empty FIFO: the push is stored; the pop is ignored (rec_valid was 0).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the rest are equal.
- Reset asserted mid-run discards the open run and all buffered records; no partial record is emitted.
- A sys_run toggle 1->0->1 on consecutive cycles: close the run (IDLE), then open a new run on the following cycle.

Optional Feature:
- Macro: RLE_TRIGGER_EN.
- Defined:
  - adds ports trig_value (input, DATA_WIDTH), trig_mask (input, DATA_WIDTH) and trig_hit (output, 1).
  - In RUN, when (data_in & trig_mask)==(trig_value & trig_mask) and the previous sample did not match, the open run is force-closed (pushed) even if the value is unchanged, and a new run starts at that sample.
  - trig_hit pulses 1 cycle, registered, on the edge that starts the new run.
  - trig_hit resets to 0.
- Undefined: none of these ports exist and the behaviour is exactly as above.

Test Plan:
- Constant data_in=16'h00A5 for 5 cycles with sys_run=1, then sys_run=0, rec_ready=1 -> exactly one record {8'd4, 16'h00A5}; run_active returns to 0.
- Sequence 1,1,2,3,3,3 with sys_run dropped after the last sample -> records {0..}: {1,0x0001}, {0,0x0002}, {2,0x0003} in order.
- Constant value for 300 cycles, CNT_WIDTH=8 -> records {255,v} then {43,v} after sys_run falls; the total repeats sum to 300.
- rec_ready=0 with alternating values 0/1 each cycle, FIFO_DEPTH=4 -> rec_valid stays 1 with rec_data stable; exactly 4 records are stored; overflow=1 on the 5th push; after rec_ready=1 the first 4 records drain in order.
- FIFO full plus simultaneous push and pop -> no drop, overflow stays 0, record order preserved.
- rst_l pulsed low mid-run with 2 records buffered -> all outputs go to 0 immediately (async); no records appear after release until a new run closes.
